// File: rtl/ysyx_23060061_mem_arbiter.sv
// ysyx_23060061_mem_arbiter: IFU/LSU round-robin arbiter
// onto a single valid/ready memory port, one transaction in flight.
module ysyx_23060061_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ifu_req_valid,
  output logic                ifu_req_ready,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_rsp_valid,
  input  logic                ifu_rsp_ready,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_req_valid,
  output logic                lsu_req_ready,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_rsp_valid,
  input  logic                lsu_rsp_ready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rsp_valid,
  output logic                mem_rsp_ready,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy,
  output logic                owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic owner_q;
  logic last_q;
  logic gnt_ifu;
  logic gnt_lsu;
  logic rsp_take;

  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] wmask_q;
  logic [DATA_W-1:0]   rdata_q;

  // next state and grant decode; a tie goes to whoever did not finish last
  always_comb begin
    state_d  = state_q;
    gnt_ifu  = 1'b0;
    gnt_lsu  = 1'b0;
    rsp_take = owner_q ? lsu_rsp_ready : ifu_rsp_ready;
    unique case (state_q)
      IDLE: begin
        gnt_lsu = lsu_req_valid &
                  (~ifu_req_valid | ~last_q);
        gnt_ifu = ifu_req_valid &
                  (~lsu_req_valid | last_q);
        if (gnt_ifu | gnt_lsu)
          state_d = ISSUE;
      end
      ISSUE: begin
        if (mem_req_ready)
          state_d = WAIT;
      end
      WAIT: begin
        if (mem_rsp_valid)
          state_d = RESP;
      end
      RESP: begin
        if (rsp_take)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state, ownership and round-robin history
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (gnt_lsu)
        owner_q <= 1'b1;
      else if (gnt_ifu)
        owner_q <= 1'b0;
      if (state_q == RESP && rsp_take)
        last_q <= owner_q;
    end
  end

  // request payload latched at grant, response latched in WAIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
    end else begin
      if (gnt_lsu) begin
        addr_q  <= lsu_addr;
        wen_q   <= lsu_wen;
        wdata_q <= lsu_wdata;
        wmask_q <= lsu_wmask;
      end else if (gnt_ifu) begin
        addr_q  <= ifu_addr;
        wen_q   <= 1'b0;
        wdata_q <= '0;
        wmask_q <= '0;
      end
      if (state_q == WAIT && mem_rsp_valid)
        rdata_q <= mem_rdata;
    end
  end

  assign ifu_req_ready = gnt_ifu;
  assign lsu_req_ready = gnt_lsu;

  assign mem_req_valid = (state_q == ISSUE);
  assign mem_rsp_ready = (state_q == WAIT);
  assign mem_addr      = addr_q;
  assign mem_wen       = wen_q;
  assign mem_wdata     = wdata_q;
  assign mem_wmask     = wmask_q;

  assign ifu_rsp_valid = (state_q == RESP) & ~owner_q;
  assign lsu_rsp_valid = (state_q == RESP) & owner_q;
  assign ifu_rdata     = rdata_q;
  assign lsu_rdata     = rdata_q;

  assign busy  = (state_q != IDLE);
  assign owner = owner_q;

endmodule

// File: tb/tb_ysyx_23060061_mem_arbiter.sv
// tb_ysyx_23060061_mem_arbiter: directed cycle table plus
// randomized traffic against a transaction-level reference.
module tb_ysyx_23060061_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic        ifu_rsp_ready;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid;
  logic        lsu_req_ready;
  logic [31:0] lsu_addr;
  logic        lsu_wen;
  logic [31:0] lsu_wdata;
  logic [3:0]  lsu_wmask;
  logic        lsu_rsp_valid;
  logic        lsu_rsp_ready;
  logic [31:0] lsu_rdata;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic        mem_rsp_ready;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        owner;

  ysyx_23060061_mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ifu_req_valid(ifu_req_valid),
    .ifu_req_ready(ifu_req_ready),
    .ifu_addr     (ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid),
    .ifu_rsp_ready(ifu_rsp_ready),
    .ifu_rdata    (ifu_rdata),
    .lsu_req_valid(lsu_req_valid),
    .lsu_req_ready(lsu_req_ready),
    .lsu_addr     (lsu_addr),
    .lsu_wen      (lsu_wen),
    .lsu_wdata    (lsu_wdata),
    .lsu_wmask    (lsu_wmask),
    .lsu_rsp_valid(lsu_rsp_valid),
    .lsu_rsp_ready(lsu_rsp_ready),
    .lsu_rdata    (lsu_rdata),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_addr     (mem_addr),
    .mem_wen      (mem_wen),
    .mem_wdata    (mem_wdata),
    .mem_wmask    (mem_wmask),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_ready(mem_rsp_ready),
    .mem_rdata    (mem_rdata),
    .busy         (busy),
    .owner        (owner)
  );

  always #5 clk = ~clk;

  // inputs:  {rst,iv,lv,mem_req_ready,mem_rsp_valid,irr,lrr}
  // outputs: {irq,lrq,mem_req_valid,mem_rsp_ready,irv,lrv,busy,owner}
  typedef struct {
    logic [6:0] i;
    logic [7:0] o;
  } vec_t;

  vec_t tbl[$];
  int   ncmp = 0;
  int   nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] i,
                     input logic [7:0] o);
    vec_t v;
    v.i = i;
    v.o = o;
    tbl.push_back(v);
  endtask

  function automatic logic [31:0] mfun(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'h1357_9bdf;
  endfunction

  // reference model state
  logic        pend, issued, got, last, mown;
  logic        p_own, p_wen;
  logic [31:0] p_addr, p_wdata;
  logic [3:0]  p_wmask;
  logic        m_owe;
  int          m_dly;
  logic [31:0] m_data;
  logic        e_ig, e_lg, e_mv, e_mr, e_irv, e_lrv;
  logic        ev_iss, ev_rsp, ev_done;

  initial begin
    rst = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    ifu_rsp_ready = 1'b0;
    lsu_rsp_ready = 1'b0;
    ifu_addr  = 32'h8000_0000;
    lsu_addr  = 32'h8000_1000;
    lsu_wen   = 1'b1;
    lsu_wdata = 32'hCAFE_BABE;
    lsu_wmask = 4'hF;
    mem_rdata = 32'h0010_0073;

    // reset, tie with LSU first
    repeat (3) add(7'b0111011, 8'b01000000);
    // round robin, zero wait
    for (int r = 0; r < 2; r++) begin
      add(7'b1111111, 8'b01000000);
      add(7'b1111111, 8'b00100011);
      add(7'b1111111, 8'b00010011);
      add(7'b1111111, 8'b00000111);
      add(7'b1111111, 8'b10000001);
      add(7'b1111111, 8'b00100010);
      add(7'b1111111, 8'b00010010);
      add(7'b1111111, 8'b00001010);
    end
    // single IFU read
    add(7'b1101111, 8'b10000000);
    add(7'b1001111, 8'b00100010);
    add(7'b1001111, 8'b00010010);
    add(7'b1001111, 8'b00001010);
    // LSU write
    add(7'b1011111, 8'b01000000);
    add(7'b1001111, 8'b00100011);
    add(7'b1001111, 8'b00010011);
    add(7'b1001111, 8'b00000111);
    // backpressure on every handshake
    add(7'b1110001, 8'b10000001);
    repeat (3) add(7'b1010001, 8'b00100010);
    add(7'b1011001, 8'b00100010);
    repeat (2) add(7'b1010001, 8'b00010010);
    add(7'b1010101, 8'b00010010);
    repeat (2) add(7'b1010001, 8'b00001010);
    add(7'b1010011, 8'b00001010);
    add(7'b1011111, 8'b01000000);
    // reset while waiting on memory
    add(7'b1001011, 8'b00100011);
    add(7'b1001011, 8'b00010011);
    add(7'b0001111, 8'b00010011);
    repeat (2) add(7'b1000111, 8'b00000000);
    add(7'b1110111, 8'b01000000);

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst mem_addr", mem_addr, 32'd0);
    chk("rst mem_wdata", mem_wdata, 32'd0);
    chk("rst mem_wmask", 32'(mem_wmask), 32'd0);
    chk("rst rdata", ifu_rdata, 32'd0);
    @(posedge clk);
    #1;

    for (int k = 0; k < tbl.size(); k++) begin
      {rst, ifu_req_valid, lsu_req_valid, mem_req_ready,
       mem_rsp_valid, ifu_rsp_ready, lsu_rsp_ready} = tbl[k].i;
      @(negedge clk);
      chk($sformatf("row%0d ctl", k),
          {24'd0, ifu_req_ready, lsu_req_ready,
           mem_req_valid, mem_rsp_ready,
           ifu_rsp_valid, lsu_rsp_valid, busy, owner},
          {24'd0, tbl[k].o});
      if (tbl[k].o[5]) begin
        if (tbl[k].o[0]) begin
          chk($sformatf("row%0d addr", k), mem_addr, 32'h8000_1000);
          chk($sformatf("row%0d wen", k), 32'(mem_wen), 32'd1);
          chk($sformatf("row%0d wdata", k), mem_wdata, 32'hCAFE_BABE);
          chk($sformatf("row%0d wmask", k), 32'(mem_wmask), 32'hF);
        end else begin
          chk($sformatf("row%0d addr", k), mem_addr, 32'h8000_0000);
          chk($sformatf("row%0d wen", k), 32'(mem_wen), 32'd0);
          chk($sformatf("row%0d wmask", k), 32'(mem_wmask), 32'd0);
        end
      end
      if (tbl[k].o[3])
        chk($sformatf("row%0d ifu_rdata", k), ifu_rdata, 32'h0010_0073);
      @(posedge clk);
      #1;
    end

    // randomized traffic
    rst = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    pend = 0; issued = 0; got = 0; last = 0; mown = 0;
    p_own = 0; p_wen = 0; p_addr = 0; p_wdata = 0; p_wmask = 0;
    m_owe = 0; m_dly = 0; m_data = 0;

    for (int c = 0; c < 3000; c++) begin
      if (!ifu_req_valid && $urandom_range(2) == 0) begin
        ifu_req_valid = 1'b1;
        ifu_addr = $urandom;
      end
      if (!lsu_req_valid && $urandom_range(2) == 0) begin
        lsu_req_valid = 1'b1;
        lsu_addr  = $urandom;
        lsu_wen   = 1'($urandom_range(1));
        lsu_wdata = $urandom;
        lsu_wmask = 4'($urandom_range(15));
      end
      mem_req_ready = 1'($urandom_range(1));
      ifu_rsp_ready = 1'($urandom_range(1));
      lsu_rsp_ready = 1'($urandom_range(1));
      if (m_owe) begin
        mem_rsp_valid = (m_dly == 0);
        mem_rdata = m_data;
      end else begin
        mem_rsp_valid = ($urandom_range(3) == 0);
        mem_rdata = $urandom;
      end

      @(negedge clk);
      e_ig  = !pend && ifu_req_valid && (!lsu_req_valid || last);
      e_lg  = !pend && lsu_req_valid && (!ifu_req_valid || !last);
      e_mv  = pend && !issued;
      e_mr  = pend && issued && !got;
      e_irv = got && !p_own;
      e_lrv = got && p_own;
      chk("rnd ifu_req_ready", 32'(ifu_req_ready), 32'(e_ig));
      chk("rnd lsu_req_ready", 32'(lsu_req_ready), 32'(e_lg));
      chk("rnd mem_req_valid", 32'(mem_req_valid), 32'(e_mv));
      chk("rnd mem_rsp_ready", 32'(mem_rsp_ready), 32'(e_mr));
      chk("rnd ifu_rsp_valid", 32'(ifu_rsp_valid), 32'(e_irv));
      chk("rnd lsu_rsp_valid", 32'(lsu_rsp_valid), 32'(e_lrv));
      chk("rnd busy", 32'(busy), 32'(pend));
      chk("rnd owner", 32'(owner), 32'(mown));
      if (e_mv) begin
        chk("rnd mem_addr", mem_addr, p_addr);
        chk("rnd mem_wen", 32'(mem_wen), 32'(p_wen));
        chk("rnd mem_wmask", 32'(mem_wmask), 32'(p_wmask));
        if (p_own)
          chk("rnd mem_wdata", mem_wdata, p_wdata);
      end
      if (got && !p_wen)
        chk("rnd rdata", p_own ? lsu_rdata : ifu_rdata, mfun(p_addr));
      ev_iss  = e_mv && mem_req_ready;
      ev_rsp  = e_mr && mem_rsp_valid;
      ev_done = got && (p_own ? lsu_rsp_ready : ifu_rsp_ready);

      @(posedge clk);
      if (m_owe && m_dly > 0)
        m_dly--;
      if (ev_done) begin
        pend = 0; issued = 0; got = 0;
        last = p_own;
      end
      if (ev_rsp) begin
        got = 1;
        m_owe = 0;
      end
      if (ev_iss) begin
        issued = 1;
        m_owe  = 1;
        m_dly  = $urandom_range(3);
        m_data = p_wen ? $urandom : mfun(p_addr);
      end
      if (e_ig) begin
        pend = 1; p_own = 0; mown = 0;
        p_addr = ifu_addr; p_wen = 0;
        p_wdata = 0; p_wmask = 0;
      end
      if (e_lg) begin
        pend = 1; p_own = 1; mown = 1;
        p_addr = lsu_addr; p_wen = lsu_wen;
        p_wdata = lsu_wdata; p_wmask = lsu_wmask;
      end
      #1;
      if (e_ig) ifu_req_valid = 1'b0;
      if (e_lg) lsu_req_valid = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
